// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN
    } state_e;

    localparam int WORD_BYTES = 4;

    localparam logic        RST_IMEM_WE    = 1'b0;
    localparam logic        RST_PROC_RESET = 1'b1;
    localparam logic        RST_BUSY       = 1'b0;
    localparam logic        RST_DONE       = 1'b0;
    localparam logic        RST_ERR        = 1'b0;
    localparam logic [31:0] RST_WORD       = 32'h0;

endpackage

// File: rtl/imem_loader.sv
// Streams instruction words into the instruction memory, then releases the processor at the load base.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of the loaded words, verified on entry to HOLD.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DEPTH       = 64,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [15:0]       load_count,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
`ifdef LOADER_CHECKSUM_EN
    input  logic [31:0]       load_chk,
    output logic [31:0]       chk_acc,
`endif
    output logic              proc_reset,
    output logic [ADDR_W-1:0] proc_startpc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH * WORD_BYTES - WORD_BYTES);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                addr_wrap_q, addr_wrap_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                proc_reset_q, proc_reset_d;
    logic [ADDR_W-1:0]   proc_startpc_q, proc_startpc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     addr_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]         chk_acc_q, chk_acc_d;
    logic [31:0]         load_chk_q, load_chk_d;
`endif

    // The extra carry bit flags a wrap past 2^ADDR_W, which must count as out of bounds.
    assign addr_inc = {1'b0, addr_q} + (ADDR_W + 1)'(WORD_BYTES);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        addr_wrap_d    = addr_wrap_q;
        remaining_d    = remaining_q;
        hold_cnt_d     = hold_cnt_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        proc_startpc_d = proc_startpc_q;
        err_d          = err_q;
`ifdef LOADER_CHECKSUM_EN
        chk_acc_d      = chk_acc_q;
        load_chk_d     = load_chk_q;
`endif

        case (state_q)
            IDLE, RUN: begin
                if (load_start) begin
                    if (load_base[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d         = load_base;
                        addr_wrap_d    = 1'b0;
                        remaining_d    = load_count;
                        hold_cnt_d     = '0;
                        proc_startpc_d = load_base;
                        err_d          = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        chk_acc_d      = RST_WORD;
                        load_chk_d     = load_chk;
`endif
                        state_d        = (load_count == 16'd0) ? HOLD : LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (addr_wrap_q || (addr_q > LAST_ADDR)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = addr_q;
                        imem_wdata_d = in_data;
                        addr_d       = addr_inc[ADDR_W-1:0];
                        addr_wrap_d  = addr_inc[ADDR_W];
                        remaining_d  = remaining_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk_acc_d    = chk_acc_q ^ in_data;
`endif
                        if (remaining_q == 16'd1) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef LOADER_CHECKSUM_EN
        // A bad checksum diverts the HOLD entry back to IDLE so the processor never starts.
        if ((state_d == HOLD) && (state_q != HOLD) && (chk_acc_d != load_chk_d)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
`endif

        proc_reset_d = (state_d != RUN);
        busy_d       = (state_d == LOAD) || (state_d == HOLD);
        done_d       = (state_d == RUN);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            addr_wrap_q    <= 1'b0;
            remaining_q    <= '0;
            hold_cnt_q     <= '0;
            imem_we_q      <= RST_IMEM_WE;
            imem_addr_q    <= '0;
            imem_wdata_q   <= RST_WORD;
            proc_reset_q   <= RST_PROC_RESET;
            proc_startpc_q <= '0;
            busy_q         <= RST_BUSY;
            done_q         <= RST_DONE;
            err_q          <= RST_ERR;
`ifdef LOADER_CHECKSUM_EN
            chk_acc_q      <= RST_WORD;
            load_chk_q     <= RST_WORD;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            addr_wrap_q    <= addr_wrap_d;
            remaining_q    <= remaining_d;
            hold_cnt_q     <= hold_cnt_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            proc_reset_q   <= proc_reset_d;
            proc_startpc_q <= proc_startpc_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
`ifdef LOADER_CHECKSUM_EN
            chk_acc_q      <= chk_acc_d;
            load_chk_q     <= load_chk_d;
`endif
        end
    end

    assign in_ready     = (state_q == LOAD);
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign proc_reset   = proc_reset_q;
    assign proc_startpc = proc_startpc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
`ifdef LOADER_CHECKSUM_EN
    assign chk_acc      = chk_acc_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table for program load/reload, hand sequences for stalls, bounds and reset.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        reset;
    logic        load_start;
    logic [63:0] load_base;
    logic [15:0] load_count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        proc_reset;
    logic [63:0] proc_startpc;
    logic        busy;
    logic        done;
    logic        err;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] load_chk = 32'h0;
    logic [31:0] chk_acc;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        rst;
        logic        start;
        logic [63:0] base;
        logic [15:0] count;
        logic        valid;
        logic [31:0] data;
        logic        e_we;
        logic [63:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_pr;
        logic [63:0] e_spc;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        logic        e_ready;
    } vec_t;

    vec_t vecs[$];

    imem_loader dut (
        .CLK          (CLK),
        .reset        (reset),
        .load_start   (load_start),
        .load_base    (load_base),
        .load_count   (load_count),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
`ifdef LOADER_CHECKSUM_EN
        .load_chk     (load_chk),
        .chk_acc      (chk_acc),
`endif
        .proc_reset   (proc_reset),
        .proc_startpc (proc_startpc),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic r, s, input logic [63:0] b, input logic [15:0] c,
                                input logic v, input logic [31:0] d,
                                input logic we, input logic [63:0] a, input logic [31:0] wd,
                                input logic pr, input logic [63:0] spc,
                                input logic bz, dn, er, rdy);
        vec_t t;
        t.rst = r; t.start = s; t.base = b; t.count = c; t.valid = v; t.data = d;
        t.e_we = we; t.e_addr = a; t.e_wdata = wd; t.e_pr = pr; t.e_spc = spc;
        t.e_busy = bz; t.e_done = dn; t.e_err = er; t.e_ready = rdy;
        return t;
    endfunction

    function automatic logic [31:0] p1_word(input int k);
        return 32'hA000_0000 | 32'(k);
    endfunction

    task automatic applyStimulus(input logic r, s, input logic [63:0] b, input logic [15:0] c,
                                 input logic v, input logic [31:0] d);
        reset      = r;
        load_start = s;
        load_base  = b;
        load_count = c;
        in_valid   = v;
        in_data    = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".we"},    imem_we,      1'b0);
        checkOutput({tag, ".addr"},  imem_addr,    64'h0);
        checkOutput({tag, ".wdata"}, imem_wdata,   32'h0);
        checkOutput({tag, ".pr"},    proc_reset,   1'b1);
        checkOutput({tag, ".spc"},   proc_startpc, 64'h0);
        checkOutput({tag, ".busy"},  busy,         1'b0);
        checkOutput({tag, ".done"},  done,         1'b0);
        checkOutput({tag, ".err"},   err,          1'b0);
        checkOutput({tag, ".ready"}, in_ready,     1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        string tag;

        // Program 1 load, zero-count reload from RUN, misaligned bases.
        vecs.push_back(mk(1,0,0,0,0,0,          0,0,0,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,          0,0,0,1,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,13,0,0,         0,0,0,1,0,1,0,0,1));
        for (int k = 0; k < 13; k++) begin
            vecs.push_back(mk(0,0,0,0,1,p1_word(k), 1,64'(4*k),p1_word(k),1,0,1,0,0,(k < 12)));
        end
        vecs.push_back(mk(0,0,0,0,0,0,          0,64'h30,p1_word(12),1,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,          0,64'h30,p1_word(12),0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,          0,64'h30,p1_word(12),0,0,0,1,0,0));
        vecs.push_back(mk(0,1,64'h40,0,0,0,     0,64'h30,p1_word(12),1,64'h40,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,          0,64'h30,p1_word(12),1,64'h40,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,          0,64'h30,p1_word(12),0,64'h40,0,1,0,0));
        vecs.push_back(mk(0,1,64'h36,5,0,0,     0,64'h30,p1_word(12),0,64'h40,0,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,          0,0,0,1,0,0,0,0,0));
        vecs.push_back(mk(0,1,64'h36,5,0,0,     0,0,0,1,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1,32'hDEAD,   0,0,0,1,0,0,0,1,0));
        vecs.push_back(mk(0,1,64'h8,0,0,0,      0,0,0,1,64'h8,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,          0,0,0,1,64'h8,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,          0,0,0,0,64'h8,0,1,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].base, vecs[i].count,
                          vecs[i].valid, vecs[i].data);
            tag = $sformatf("vec%0d", i);
            checkOutput({tag, ".we"},    imem_we,      vecs[i].e_we);
            checkOutput({tag, ".addr"},  imem_addr,    vecs[i].e_addr);
            checkOutput({tag, ".wdata"}, imem_wdata,   vecs[i].e_wdata);
            checkOutput({tag, ".pr"},    proc_reset,   vecs[i].e_pr);
            checkOutput({tag, ".spc"},   proc_startpc, vecs[i].e_spc);
            checkOutput({tag, ".busy"},  busy,         vecs[i].e_busy);
            checkOutput({tag, ".done"},  done,         vecs[i].e_done);
            checkOutput({tag, ".err"},   err,          vecs[i].e_err);
            checkOutput({tag, ".ready"}, in_ready,     vecs[i].e_ready);
        end

        // Program 2 with a 1/0 in_valid pattern and an ignored load_start mid-load.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 64'h34, 10, 0, 0);
        checkOutput("p2.start.ready", in_ready, 1'b1);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(0, (c == 5), (c == 5) ? 64'h80 : 64'h0, 3, (c % 2 == 0), 32'h2000 + 32'(n));
            if (c % 2 == 0) begin
                checkOutput($sformatf("p2.c%0d.we", c),    imem_we,    1'b1);
                checkOutput($sformatf("p2.c%0d.addr", c),  imem_addr,  64'h34 + 64'(4 * n));
                checkOutput($sformatf("p2.c%0d.wdata", c), imem_wdata, 32'h2000 + 32'(n));
                n++;
            end else begin
                checkOutput($sformatf("p2.c%0d.we", c), imem_we, 1'b0);
            end
        end
        checkOutput("p2.hold2.pr", proc_reset, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("p2.run.pr",   proc_reset,   1'b0);
        checkOutput("p2.run.done", done,         1'b1);
        checkOutput("p2.run.spc",  proc_startpc, 64'h34);
        checkOutput("p2.run.addr", imem_addr,    64'h58);

        // Out-of-bounds: two legal writes at the top of memory, then an abort.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 64'hF8, 4, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h11);
        checkOutput("oob.w0.we",   imem_we,   1'b1);
        checkOutput("oob.w0.addr", imem_addr, 64'hF8);
        applyStimulus(0, 0, 0, 0, 1, 32'h22);
        checkOutput("oob.w1.we",   imem_we,   1'b1);
        checkOutput("oob.w1.addr", imem_addr, 64'hFC);
        applyStimulus(0, 0, 0, 0, 1, 32'h33);
        checkOutput("oob.w2.we",    imem_we,    1'b0);
        checkOutput("oob.w2.err",   err,        1'b1);
        checkOutput("oob.w2.busy",  busy,       1'b0);
        checkOutput("oob.w2.pr",    proc_reset, 1'b1);
        checkOutput("oob.w2.ready", in_ready,   1'b0);
        applyStimulus(0, 0, 0, 0, 1, 32'h44);
        checkOutput("oob.w3.we",   imem_we, 1'b0);
        checkOutput("oob.w3.done", done,    1'b0);

        // Reset after 3 of 10 words returns every output to its reset value.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 64'h0, 10, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 32'h5550 + 32'(k));
        end
        checkOutput("mid.pre.addr", imem_addr, 64'h8);
        applyStimulus(1, 0, 0, 0, 1, 32'hFFFF);
        checkResetValues("mid.rst");

`ifdef LOADER_CHECKSUM_EN
        // Matching checksum reaches RUN; a mismatched one aborts to IDLE.
        applyStimulus(1, 0, 0, 0, 0, 0);
        load_chk = 32'h7;
        applyStimulus(0, 1, 64'h0, 3, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h1);
        applyStimulus(0, 0, 0, 0, 1, 32'h2);
        applyStimulus(0, 0, 0, 0, 1, 32'h4);
        checkOutput("chk.ok.acc", chk_acc, 32'h7);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("chk.ok.done", done, 1'b1);
        checkOutput("chk.ok.err",  err,  1'b0);
        load_chk = 32'h6;
        applyStimulus(0, 1, 64'h0, 3, 0, 0);
        checkOutput("chk.bad.clr", chk_acc, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 32'h1);
        applyStimulus(0, 0, 0, 0, 1, 32'h2);
        applyStimulus(0, 0, 0, 0, 1, 32'h4);
        checkOutput("chk.bad.err",  err,        1'b1);
        checkOutput("chk.bad.busy", busy,       1'b0);
        checkOutput("chk.bad.pr",   proc_reset, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("chk.bad.done", done, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
